// File: rtl/packed_array_scanner.sv
// ROWS x COLS array of WIDTH-bit elements, writable per element, streamed out over valid/ready.
// Optional OUT_PARITY output enabled by defining PACKED_ARRAY_SCANNER_PARITY_EN.
module packed_array_scanner #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROWS  = 3,
    parameter int unsigned COLS  = 2,
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WR_EN,
    input  logic [RW-1:0]               WR_ROW,
    input  logic [CW-1:0]               WR_COL,
    input  logic [WIDTH-1:0]            WR_DATA,
    input  logic                        START,
    input  logic                        COL_MAJOR,
    output logic                        BUSY,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [WIDTH-1:0]            OUT_DATA,
    output logic [RW-1:0]               OUT_ROW,
    output logic [CW-1:0]               OUT_COL,
    output logic                        OUT_LAST,
`ifdef PACKED_ARRAY_SCANNER_PARITY_EN
    output logic                        OUT_PARITY,
`endif
    output logic [ROWS*COLS*WIDTH-1:0]  FLAT_OUT
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned EW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StScan = 1'b1;

    typedef logic [N-1:0][WIDTH-1:0] arr_t;

    function automatic arr_t init_pattern();
        arr_t a;
        for (int i = 0; i < int'(N); i++) begin
            a[EW'(i)] = WIDTH'(i);
        end
        return a;
    endfunction

    localparam arr_t InitPattern = init_pattern();

    function automatic logic [EW-1:0] elem_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return EW'(32'(r) * COLS + 32'(c));
    endfunction

    arr_t             arr_q, arr_d;
    arr_t             flat_q;
    logic [0:0]       state_q, state_d;
    logic             col_major_q, col_major_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             par_q, par_d;

    logic             wr_ok;
    logic [EW-1:0]    wr_idx;
    logic             load;
    logic [RW-1:0]    load_row, nxt_row;
    logic [CW-1:0]    load_col, nxt_col;
    logic [EW-1:0]    load_idx;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        wr_ok  = WR_EN && (32'(WR_ROW) < ROWS) && (32'(WR_COL) < COLS);
        wr_idx = elem_idx(WR_ROW, WR_COL);
        arr_d  = arr_q;
        if (wr_ok) begin
            arr_d[wr_idx] = WR_DATA;
        end
    end

    // Successor of the element currently presented, in the latched scan order.
    always_comb begin
        nxt_row = row_q;
        nxt_col = col_q;
        if (col_major_q) begin
            if (row_q == RW'(ROWS - 1)) begin
                nxt_row = '0;
                nxt_col = col_q + CW'(1);
            end else begin
                nxt_row = row_q + RW'(1);
            end
        end else begin
            if (col_q == CW'(COLS - 1)) begin
                nxt_col = '0;
                nxt_row = row_q + RW'(1);
            end else begin
                nxt_col = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_major_d = col_major_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        last_d      = last_q;
        par_d       = par_q;
        load        = 1'b0;
        load_row    = '0;
        load_col    = '0;

        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d     = StScan;
                    col_major_d = COL_MAJOR;
                    load        = 1'b1;
                end
            end
            StScan: begin
                if (OUT_READY) begin
                    if (last_q) begin
                        state_d = StIdle;
                        last_d  = 1'b0;
                    end else begin
                        load     = 1'b1;
                        load_row = nxt_row;
                        load_col = nxt_col;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A same-edge write to the element being loaded wins over the stored value.
        load_idx  = elem_idx(load_row, load_col);
        load_data = (wr_ok && (wr_idx == load_idx)) ? WR_DATA : arr_q[load_idx];

        if (load) begin
            row_d  = load_row;
            col_d  = load_col;
            data_d = load_data;
            par_d  = ^load_data;
            last_d = (load_row == RW'(ROWS - 1)) && (load_col == CW'(COLS - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            arr_q       <= InitPattern;
            flat_q      <= InitPattern;
            state_q     <= StIdle;
            col_major_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            par_q       <= 1'b0;
        end else begin
            arr_q       <= arr_d;
            flat_q      <= arr_q;
            state_q     <= state_d;
            col_major_q <= col_major_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            last_q      <= last_d;
            par_q       <= par_d;
        end
    end

    assign BUSY      = (state_q == StScan);
    assign OUT_VALID = (state_q == StScan);
    assign OUT_DATA  = data_q;
    assign OUT_ROW   = row_q;
    assign OUT_COL   = col_q;
    assign OUT_LAST  = last_q;
    assign FLAT_OUT  = flat_q;
`ifdef PACKED_ARRAY_SCANNER_PARITY_EN
    assign OUT_PARITY = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: doc/packed_array_scanner.md
Name: packed_array_scanner

Overview:
- Parametrised successor to the fixed 4x3 / 3x2x8 packed-array constant blocks: a ROWS x COLS array of WIDTH-bit elements held in a single packed register.
- Reset-initialised to a linear index pattern and writable per element.
- A scan engine streams elements out over a valid/ready interface in row-major or column-major order.
- Used as a configurable coefficient/test-pattern source feeding downstream datapath blocks.

Parameters:
- WIDTH, 8, element bit width (>=2).
- ROWS, 3, number of rows (>=1).
- COLS, 2, number of columns (>=1).
- RW = max(1,$clog2(ROWS)) and CW = max(1,$clog2(COLS)) are derived localparams, not overridable.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- WR_EN  in  1  element write strobe.
- WR_ROW  in  RW  write row index.
- WR_COL  in  CW  write column index.
- WR_DATA  in  WIDTH  write data.
- START  in  1  scan request pulse.
- COL_MAJOR  in  1  scan order, sampled with START: 0 = row-major, 1 = column-major.
- BUSY  out  1  scan in progress.
- OUT_VALID  out  1  output element valid.
- OUT_READY  in  1  downstream ready.
- OUT_DATA  out  WIDTH  element value.
- OUT_ROW  out  RW  element row index.
- OUT_COL  out  CW  element column index.
- OUT_LAST  out  1  final element of scan.
- FLAT_OUT  out  ROWS*COLS*WIDTH  registered packed array image; element [r][c] occupies bits [(r*COLS+c)*WIDTH +: WIDTH].

Behaviour:
- All outputs are registered.
- Reset:
  - Element [r][c] loads (r*COLS+c) mod 2^WIDTH.
  - BUSY=0, OUT_VALID=0, OUT_DATA=0, OUT_ROW=0, OUT_COL=0, OUT_LAST=0.
  - FLAT_OUT shows the reset pattern one cycle after RST deasserts.
  - RST mid-scan aborts to IDLE immediately; no further beats are emitted.
- Writes:
  - WR_EN with WR_ROW<ROWS and WR_COL<COLS updates the element at the next edge.
  - Out-of-range indices are ignored entirely.
  - FLAT_OUT reflects a write 2 cycles after WR_EN (array register, then output register).
- FSM has two states, IDLE and SCAN.
- IDLE -> SCAN:
  - START=1 latches COL_MAJOR and moves to SCAN.
  - BUSY=1 and OUT_VALID=1 on the next cycle, presenting element [0][0] with OUT_ROW=0, OUT_COL=0.
  - Start-to-first-beat latency is 1 cycle.
- SCAN:
  - A transfer occurs on any edge with OUT_VALID&&OUT_READY.
  - On transfer of a non-last element, the next element is presented on the following cycle.
  - OUT_VALID stays high with no bubbles, giving 1 beat/cycle under continuous ready.
  - Without a transfer, OUT_DATA/ROW/COL/LAST are held stable.
- Scan order:
  - Row-major: column index increments fastest; when it wraps COLS-1 -> 0, the row increments.
  - Column-major: row index increments fastest; when it wraps ROWS-1 -> 0, the column increments.
- OUT_LAST=1 exactly while presenting [ROWS-1][COLS-1].
- SCAN -> IDLE: on transfer of the last element, the next cycle has OUT_VALID=0, BUSY=0, OUT_LAST=0.
- START while BUSY=1 is ignored. A new START is accepted in the first cycle BUSY=0.
- Degenerate size ROWS=COLS=1: a single beat with OUT_LAST=1.
- Data capture rules:
  - OUT_DATA is captured from the array when an element is loaded for presentation.
  - A later write to that element does not change the presented beat.
  - Writes to not-yet-presented elements are visible when those elements are loaded.
- Write and load in the same edge, targeting the element being loaded: WR_DATA is presented (write-first bypass).

Optional Feature:
- Macro PACKED_ARRAY_SCANNER_PARITY_EN.
- Defined:
  - Adds output OUT_PARITY (1 bit) = XOR-reduction of OUT_DATA, registered alongside OUT_DATA with identical timing and hold rules.
  - OUT_PARITY reset value is 0.
- Undefined: the port and logic are absent; all other behaviour is unchanged.

Test Plan:
- Defaults, reset then START with COL_MAJOR=0 and READY=1 -> 6 consecutive beats with DATA 0,1,2,3,4,5, (ROW,COL)=(0,0),(0,1),(1,0),(1,1),(2,0),(2,1); LAST only on beat 6; BUSY low the cycle after.
- START with COL_MAJOR=1, READY=1 -> DATA 0,2,4,1,3,5; LAST on DATA 5.
- Write [1][0]=0xA5 and write [3][0]=0xFF (ignored), then wait 2 cycles -> FLAT_OUT bits [23:16]=0xA5 and FLAT_OUT otherwise equal to the reset pattern; a subsequent row-major scan yields 0,1,0xA5,3,4,5.
- Row-major scan with READY toggling 1,0,0,1 per cycle -> beats held stable while READY=0; all 6 values are delivered exactly once, in order.
- START pulsed again mid-scan, and RST asserted at beat 3 of a second scan -> the repeated START has no effect; after RST, OUT_VALID=0 and BUSY=0 next cycle, and the array is back to 0..5.
- ROWS=1, COLS=1, WIDTH=4 with PARITY_EN defined: write 0x7 then START -> single beat DATA=0x7, LAST=1, OUT_PARITY=1.
